// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM driver: state encoding, widths,
// and the position-to-pulse-width mapping.
package servo_pkg;

  localparam int unsigned POS_W    = 10;
  localparam int unsigned US_CNT_W = 15;
  localparam int unsigned PROD_W   = POS_W + 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } servoState_t;

  // Pulse width in microseconds: minUs + (pos * spanUs) / 2^POS_W
  function automatic logic [US_CNT_W-1:0] calcWidthUs(
    input logic [POS_W-1:0] pos,
    input int unsigned      minUs,
    input int unsigned      spanUs
  );
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(pos) * PROD_W'(spanUs);
    return US_CNT_W'(minUs + 32'(prod >> POS_W));
  endfunction

endpackage

// File: rtl/servo_us_prescaler.sv
// Microsecond tick generator: us_tick pulses once every CLK_HZ/1e6 clocks;
// clear restarts the count so a new frame is cycle-aligned.
module servo_us_prescaler #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic us_tick
);

  localparam int unsigned DIV   = CLK_HZ / 1000000;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext_c;

  always_comb begin
    cntNext_c = (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
  end

  // Tick is registered one cycle ahead so it coincides with cnt == DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      us_tick <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      us_tick <= (DIV == 1);
    end else begin
      cnt     <= cntNext_c;
      us_tick <= (cntNext_c == CNT_W'(DIV - 1));
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// Hobby-servo PWM generator: fixed frame, 1-2 ms pulse, position sampled once
// per frame. Optional macro SERVO_SLEW_LIMIT_EN limits per-frame position change.
module servo_pwm_driver #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned MIN_US   = 1000,
  parameter int unsigned SPAN_US  = 1000,
  parameter int unsigned POS_W    = servo_pkg::POS_W,
  parameter int unsigned MAX_STEP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [POS_W-1:0] position,
  output logic             pwm_out,
  output logic             frame_start,
  output logic [POS_W-1:0] active_pos
);

  import servo_pkg::*;

`ifdef SERVO_SLEW_LIMIT_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif
  // Without slew limiting the step bound exceeds any possible distance
  localparam int unsigned STEP_LIM = SLEW_ON ? MAX_STEP : (1 << POS_W);

  servoState_t         state;
  logic                usTick;
  logic [US_CNT_W-1:0] usCnt;
  logic [US_CNT_W-1:0] usCntInc_c;
  logic [US_CNT_W-1:0] widthUs_c;
  logic                pulseEnd_c;
  logic                frameEnd_c;
  logic                startFrame_c;
  logic [POS_W:0]      posDiff_c;
  logic [POS_W-1:0]    nextPos_c;

  servo_us_prescaler #(.CLK_HZ(CLK_HZ)) uPrescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (startFrame_c),
    .us_tick(usTick)
  );

  // Boundaries use the incremented count so edges land exactly on N us
  always_comb begin
    usCntInc_c   = usCnt + US_CNT_W'(1);
    widthUs_c    = calcWidthUs(active_pos, MIN_US, SPAN_US);
    pulseEnd_c   = usTick && (usCntInc_c == widthUs_c);
    frameEnd_c   = usTick && (usCntInc_c == US_CNT_W'(FRAME_US));
    startFrame_c = !reset && enable && ((state == IDLE) || ((state == LOW) && frameEnd_c));

    if (position >= active_pos) begin
      posDiff_c = {1'b0, position} - {1'b0, active_pos};
      nextPos_c = (posDiff_c > (POS_W + 1)'(STEP_LIM)) ? active_pos + POS_W'(STEP_LIM) : position;
    end else begin
      posDiff_c = {1'b0, active_pos} - {1'b0, position};
      nextPos_c = (posDiff_c > (POS_W + 1)'(STEP_LIM)) ? active_pos - POS_W'(STEP_LIM) : position;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      active_pos  <= '0;
      usCnt       <= '0;
    end else begin
      frame_start <= 1'b0;
      if (startFrame_c) begin
        state       <= HIGH;
        pwm_out     <= 1'b1;
        frame_start <= 1'b1;
        active_pos  <= nextPos_c;
        usCnt       <= '0;
      end else begin
        case (state)
          HIGH: begin
            if (usTick) usCnt <= usCntInc_c;
            if (pulseEnd_c) begin
              state   <= LOW;
              pwm_out <= 1'b0;
            end
          end
          LOW: begin
            if (frameEnd_c) begin
              state <= IDLE;
              usCnt <= '0;
            end else if (usTick) begin
              usCnt <= usCntInc_c;
            end
          end
          default: begin
            state   <= IDLE;
            pwm_out <= 1'b0;
            usCnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed bench for servo_pwm_driver at 2 MHz / 2500 us frame (2 clk per us,
// 5000 clk per frame) with hand-computed pulse widths.
module tb_servo_pwm_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] position;
  logic       pwmOut;
  logic       frameStart;
  logic [9:0] activePos;

  int testCount = 0;
  int failCount = 0;

  int highCyc;
  int periodCyc;
  bit posStable;
  bit gotNext;

  servo_pwm_driver #(
    .CLK_HZ  (2000000),
    .FRAME_US(2500),
    .MIN_US  (1000),
    .SPAN_US (1000),
    .POS_W   (10),
    .MAX_STEP(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .position   (position),
    .pwm_out    (pwmOut),
    .frame_start(frameStart),
    .active_pos (activePos)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts on a negedge where frameStart is high; ends on the next frameStart or at bound
  task automatic runFrame(input int bound, input bit toggle, input int dropAt,
                          output int hiCyc, output int perCyc, output bit stable, output bit nextSeen);
    logic [9:0] p0;
    p0     = activePos;
    hiCyc  = 0;
    perCyc = 0;
    stable = 1'b1;
    do begin
      if (pwmOut === 1'b1) hiCyc++;
      if (activePos !== p0) stable = 1'b0;
      perCyc++;
      if (toggle && (perCyc % 1000 == 0)) position = (position == 10'd100) ? 10'd900 : 10'd100;
      if (perCyc == dropAt) enable = 1'b0;
      @(negedge clk);
    end while (frameStart !== 1'b1 && perCyc < bound);
    nextSeen = (frameStart === 1'b1);
  endtask

`ifdef SERVO_SLEW_LIMIT_EN
  logic [9:0] slewExp [8] = '{10'd16, 10'd32, 10'd48, 10'd64, 10'd80, 10'd96, 10'd100, 10'd100};
`endif

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    position = 10'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkEq("rst_pwm", 32'(pwmOut), 32'd0);
      checkEq("rst_fs", 32'(frameStart), 32'd0);
      checkEq("rst_ap", 32'(activePos), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkEq("fs_before_first_edge", 32'(frameStart), 32'd0);
    @(negedge clk);
    checkEq("first_fs", 32'(frameStart), 32'd1);
    checkEq("first_pwm_rise", 32'(pwmOut), 32'd1);
    checkEq("first_ap", 32'(activePos), 32'd0);

`ifdef SERVO_SLEW_LIMIT_EN
    position = 10'd100;
    runFrame(6000, 1'b0, -1, highCyc, periodCyc, posStable, gotNext);
    for (int i = 0; i < 8; i++) begin
      checkEq($sformatf("slew_ap_%0d", i), 32'(activePos), 32'(slewExp[i]));
      runFrame(6000, 1'b0, -1, highCyc, periodCyc, posStable, gotNext);
      checkEq($sformatf("slew_next_%0d", i), 32'(gotNext), 32'd1);
    end
`else
    // Position 0: 1000 us high
    position = 10'd512;
    runFrame(6000, 1'b0, -1, highCyc, periodCyc, posStable, gotNext);
    checkEq("p0_high", 32'(highCyc), 32'd2000);
    checkEq("p0_period", 32'(periodCyc), 32'd5000);
    checkEq("p0_next", 32'(gotNext), 32'd1);

    // Position 512: 1500 us high, back-to-back frame
    checkEq("p512_ap", 32'(activePos), 32'd512);
    checkEq("p512_pwm_rise", 32'(pwmOut), 32'd1);
    position = 10'd1023;
    runFrame(6000, 1'b0, -1, highCyc, periodCyc, posStable, gotNext);
    checkEq("p512_high", 32'(highCyc), 32'd3000);
    checkEq("p512_period", 32'(periodCyc), 32'd5000);

    // Position 1023: 1999 us high
    checkEq("p1023_ap", 32'(activePos), 32'd1023);
    position = 10'd100;
    runFrame(6000, 1'b0, -1, highCyc, periodCyc, posStable, gotNext);
    checkEq("p1023_high", 32'(highCyc), 32'd3998);
    checkEq("p1023_period", 32'(periodCyc), 32'd5000);

    // Mid-frame toggling: 5 toggles per frame, so sampled value alternates
    checkEq("tog1_ap", 32'(activePos), 32'd100);
    runFrame(6000, 1'b1, -1, highCyc, periodCyc, posStable, gotNext);
    checkEq("tog1_high", 32'(highCyc), 32'd2194);
    checkEq("tog1_stable", 32'(posStable), 32'd1);
    checkEq("tog2_ap", 32'(activePos), 32'd900);
    runFrame(6000, 1'b1, -1, highCyc, periodCyc, posStable, gotNext);
    checkEq("tog2_high", 32'(highCyc), 32'd3756);
    checkEq("tog2_stable", 32'(posStable), 32'd1);
    checkEq("tog3_ap", 32'(activePos), 32'd100);

    position = 10'd512;
    runFrame(6000, 1'b0, -1, highCyc, periodCyc, posStable, gotNext);
    checkEq("p100_high", 32'(highCyc), 32'd2194);

    // Enable dropped 10 us into a 1500 us pulse
    checkEq("drop_ap", 32'(activePos), 32'd512);
    runFrame(5200, 1'b0, 20, highCyc, periodCyc, posStable, gotNext);
    checkEq("drop_high", 32'(highCyc), 32'd3000);
    checkEq("drop_no_next_fs", 32'(gotNext), 32'd0);
    checkEq("drop_idle_pwm", 32'(pwmOut), 32'd0);

    enable = 1'b1;
    @(negedge clk);
    checkEq("reenable_fs", 32'(frameStart), 32'd1);
    checkEq("reenable_ap", 32'(activePos), 32'd512);
`endif

    // Reset in the middle of a pulse
    repeat (100) @(negedge clk);
    checkEq("pre_rst_pwm", 32'(pwmOut), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkEq("midrst_pwm", 32'(pwmOut), 32'd0);
    checkEq("midrst_fs", 32'(frameStart), 32'd0);
    checkEq("midrst_ap", 32'(activePos), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
Name: servo_pwm_driver

Overview:
Converts the 10-bit servo position word from the sorter/maintenance select path into a standard hobby-servo PWM waveform. Timing is a fixed 20 ms frame with a 1.0-2.0 ms high pulse. Position is sampled once per frame, so mid-frame changes on the select path never distort a pulse. Sits between the servo command mux and the physical servo pin.

Parameters:
CLK_HZ, 50000000, system clock frequency; must be an integer multiple of 1 MHz
FRAME_US, 20000, PWM frame period in microseconds
MIN_US, 1000, pulse width for position 0
SPAN_US, 1000, added pulse width at full scale
POS_W, 10, position word width
MAX_STEP, 16, per-frame position change limit (only used with slew feature)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
enable  input  1  1 = generate frames; 0 = finish current frame, then idle low
position  input  POS_W  commanded servo position (0..1023)
pwm_out  output  1  servo PWM pin
frame_start  output  1  one-cycle pulse on the first clk of each frame
active_pos  output  POS_W  position latched for the current frame

Behaviour:
- Single clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset values: pwm_out=0, frame_start=0, active_pos=0, state=IDLE, all counters=0.
- A microsecond tick (us_tick) pulses every CLK_HZ/1e6 clk cycles.
  - The prescaler is cleared by reset and on the IDLE->HIGH transition, so every frame is cycle-exact.
- Pulse width: width_us = MIN_US + ((active_pos * SPAN_US) >> POS_W).
  - Intermediate product is POS_W+10 bits wide.
  - pos 0 -> 1000 us; 512 -> 1500 us; 1023 -> 1999 us.
- State machine: IDLE, HIGH, LOW.
  - IDLE: pwm_out=0. If enable=1, then on the next clk:
    - latch position into active_pos;
    - assert frame_start for one cycle;
    - clear us_cnt;
    - go to HIGH.
  - HIGH: pwm_out=1. When us_cnt reaches width_us, go to LOW.
  - LOW: pwm_out=0. When us_cnt reaches FRAME_US:
    - if enable=1, latch a new position, pulse frame_start, clear us_cnt, go to HIGH (back-to-back frames, no gap cycle);
    - otherwise go to IDLE.
- us_cnt increments on us_tick and runs across the whole frame. It is 15 bits wide and never wraps within a frame.
- Latency: position sampled at frame_start; pwm_out rises on the same cycle frame_start is high.
- enable is sampled only at frame boundaries. A deassertion mid-frame never truncates a pulse or a frame.
- Position changes mid-frame are ignored until the next frame boundary.
- Reset mid-pulse: pwm_out drops to 0 on the next edge and the FSM returns to IDLE.
- Reset and enable both high: reset wins.

Optional Feature:
Macro SERVO_SLEW_LIMIT_EN.
- Defined: at each frame boundary, active_pos moves toward position by at most MAX_STEP. Target is reached exactly with no overshoot, and the result is clamped to 0..1023.
  - Reset still forces active_pos=0.
  - The first frame after reset slews up from 0.
- Undefined: active_pos = position directly at each frame boundary.

Decomposition:
- Shared package servo_pkg holds:
  - state encoding (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - POS_W default;
  - the width_us calculation as a function;
  - US_CNT_W=15.
- One sub-module, servo_us_prescaler:
  - parameter CLK_HZ;
  - inputs clk, reset, clear;
  - output us_tick.

Test Plan:
- reset=1 for 3 cycles, enable=1 during reset -> pwm_out=0, frame_start=0, active_pos=0 throughout; first frame_start appears 1 clk after reset falls.
- enable=1, position=0 -> pwm_out high 50000 clk, low 950000 clk, frame_start period exactly 1000000 clk.
- position=512 then 1023 on consecutive frames -> high times 75000 clk then 99950 clk; no gap cycle between frames.
- position toggles 100<->900 every 1000 clk mid-frame -> pulse width equals the value sampled at frame_start only; active_pos stable within the frame.
- enable dropped 10 us into a pulse at position 512 -> that pulse completes at 1500 us, frame completes at 20000 us, then IDLE with pwm_out=0 and no further frame_start.
- With SERVO_SLEW_LIMIT_EN, MAX_STEP=16, step position 0->100 -> active_pos sequence 16,32,48,64,80,96,100,100; reset asserted mid-pulse -> pwm_out=0 next clk.
